// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and types for the instruction-fetch stage.
//   XLEN             - datapath width
//   NOP_INST         - bubble word (addi x0,x0,0) placed in IF/ID on flush/halt
//   RESET_PC_DEFAULT - default reset fetch address
//   fetch_state_e    - fetch FSM encoding (RUN / HALT)
package fetch_pkg;

  localparam int unsigned XLEN             = 32;
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// if_id_reg: IF/ID pipeline register holding pc, pc+4, instruction and valid.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   load                - capture pc_in/inst_in as a valid instruction
//   flush               - replace contents with a NOP bubble (beats hold)
//   hold                - keep current contents
//   pc_in, inst_in      - incoming fetch address and word
//   pc, pc4, inst, valid - registered contents
module if_id_reg
  import fetch_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            flush,
  input  logic            hold,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] inst_in,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc4,
  output logic [XLEN-1:0] inst,
  output logic            valid
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc4_q, pc4_d;
  logic [XLEN-1:0] inst_q, inst_d;
  logic            valid_q, valid_d;

  // Next-contents selection: flush > hold > load; no request keeps contents.
  always_comb begin
    pc_d    = pc_q;
    pc4_d   = pc4_q;
    inst_d  = inst_q;
    valid_d = valid_q;
    if (flush) begin
      pc_d    = 32'h0000_0000;
      pc4_d   = 32'h0000_0000;
      inst_d  = NOP_INST;
      valid_d = 1'b0;
    end else if (hold) begin
      pc_d    = pc_q;
    end else if (load) begin
      pc_d    = pc_in;
      pc4_d   = pc_in + 32'd4;
      inst_d  = inst_in;
      valid_d = 1'b1;
    end else begin
      pc_d    = pc_q;
    end
  end

  // Pipeline register state with synchronous reset to an empty bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= 32'h0000_0000;
      pc4_q   <= 32'h0000_0000;
      inst_q  <= NOP_INST;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
    end
  end

  assign pc    = pc_q;
  assign pc4   = pc4_q;
  assign inst  = inst_q;
  assign valid = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage. Owns the PC, presents it to a
// combinational instruction memory, and registers the returned word into IF/ID.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   stall         - hold PC and IF/ID this cycle
//   redirect      - taken branch/jump: load redirect_pc, flush IF/ID
//   redirect_pc   - redirect target (low two bits ignored)
//   PC            - registered fetch address to instruction memory
//   Inst          - instruction word for PC (same cycle)
//   if_id_pc/pc4/inst/valid - IF/ID register contents
//   halted        - fetch stopped
//   fetch_count   - instructions accepted into IF/ID
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = RESET_PC_DEFAULT,
  parameter int unsigned MEM_DEPTH    = 64,
  parameter bit          HALT_ON_ZERO = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] PC,
  input  logic [XLEN-1:0] Inst,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] if_id_pc4,
  output logic [XLEN-1:0] if_id_inst,
  output logic            if_id_valid,
  output logic            halted,
  output logic [XLEN-1:0] fetch_count
);

  // Byte address one past the last instruction word; compared unsigned.
  localparam logic [31:0] MEM_LIMIT = 32'(MEM_DEPTH) * 32'd4;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] count_q, count_d;
  logic            end_det_s;
  logic            load_s, flush_s, hold_s;

  // A zero word is treated as unprogrammed memory; it is never issued.
  assign end_det_s = (HALT_ON_ZERO && (Inst == 32'h0000_0000)) || (pc_q >= MEM_LIMIT);

  // Next-state, next-PC and IF/ID control; redirect > stall > end-detect > normal.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q;
    load_s  = 1'b0;
    flush_s = 1'b0;
    hold_s  = 1'b0;
    if (redirect) begin
      state_d = ST_RUN;
      pc_d    = {redirect_pc[31:2], 2'b00};
      flush_s = 1'b1;
    end else if (stall) begin
      hold_s  = 1'b1;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (end_det_s) begin
            state_d = ST_HALT;
            flush_s = 1'b1;
          end else begin
            pc_d    = pc_q + 32'd4;
            count_d = count_q + 32'd1;
            load_s  = 1'b1;
          end
        end
        ST_HALT: begin
          flush_s = 1'b1;
        end
        default: begin
          state_d = ST_HALT;
          flush_s = 1'b1;
        end
      endcase
    end
  end

  // PC, FSM state and fetch counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      count_q <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
    end
  end

  if_id_reg u_if_id_reg (
    .clk     (clk),
    .rst     (rst),
    .load    (load_s),
    .flush   (flush_s),
    .hold    (hold_s),
    .pc_in   (pc_q),
    .inst_in (Inst),
    .pc      (if_id_pc),
    .pc4     (if_id_pc4),
    .inst    (if_id_inst),
    .valid   (if_id_valid)
  );

  assign PC          = pc_q;
  assign halted      = (state_q == ST_HALT);
  assign fetch_count = count_q;

endmodule
